// File: rtl/nn_arbiter_if.sv
// Bundle of request, datapath and response signals around the two-requester neuron arbiter.
// The slave view belongs to the arbiter; the master view belongs to its environment.
interface nn_arbiter_if #(
  parameter int unsigned W = 32
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [4*W-1:0] req0_x;
  logic [4*W-1:0] req1_x;
  logic           dp_start;
  logic [W-1:0]   dp_x1;
  logic [W-1:0]   dp_x2;
  logic [W-1:0]   dp_x3;
  logic [W-1:0]   dp_x4;
  logic           dp_done;
  logic [W-1:0]   dp_out;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  modport slave (
    input  req_valid, req0_x, req1_x, dp_done, dp_out, rsp_ready,
    output req_ready, dp_start, dp_x1, dp_x2, dp_x3, dp_x4,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req0_x, req1_x, dp_done, dp_out, rsp_ready,
    input  req_ready, dp_start, dp_x1, dp_x2, dp_x3, dp_x4,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/nn_arbiter.sv
// Round-robin arbiter sharing one neuron datapath between two requesters, one operation
// in flight at a time, with a bounded wait for datapath completion.
module nn_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  nn_arbiter_if.slave bus
);
  localparam int unsigned    CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StRespond} state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           owner_q, owner_d;
  logic           err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4*W-1:0] x_q, x_d;
  logic [W-1:0]   data_q, data_d;

  logic           gnt_idx;
  logic [1:0]     req_ready;
  logic           dp_start;

  // A lone requester always wins; with both (or none) valid, favour the one not served last.
  always_comb begin
    case (bus.req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      default: gnt_idx = ~last_grant_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    data_d       = data_q;
    req_ready    = 2'b00;
    dp_start     = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = gnt_idx ? 2'b10 : 2'b01;
        if (|(bus.req_valid & req_ready)) begin
          x_d     = gnt_idx ? bus.req1_x : bus.req0_x;
          owner_d = gnt_idx;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        dp_start = 1'b1;
        cnt_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        // Completion takes priority over a timeout landing in the same cycle.
        if (bus.dp_done) begin
          data_d  = bus.dp_out;
          err_d   = 1'b0;
          state_d = StRespond;
        end else if (cnt_q == CntLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StRespond;
        end
      end
      StRespond: begin
        if (bus.rsp_ready) begin
          last_grant_d = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      x_q          <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      data_q       <= data_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.dp_start  = dp_start;
  assign bus.dp_x1     = x_q[W-1:0];
  assign bus.dp_x2     = x_q[2*W-1:W];
  assign bus.dp_x3     = x_q[3*W-1:2*W];
  assign bus.dp_x4     = x_q[4*W-1:3*W];
  assign bus.rsp_valid = (state_q == StRespond);
  assign bus.rsp_id    = owner_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
endmodule
